// File: rtl/gray_if_pkg.sv
// Shared definitions for the gray-image responder: widths, image size and FSM encoding.
package gray_if_pkg;

   localparam int unsigned GRAY_ADDR_W     = 14;
   localparam int unsigned GRAY_DATA_W     = 8;
   localparam int unsigned GRAY_IMG_W      = 128;
   localparam int unsigned IMG_PIXELS      = 16384;
   localparam int unsigned FRAME_CNT_W     = 8;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DRAIN = 2'd2
   } gray_state_e;

endpackage

// File: rtl/gray_img_ram.sv
// Image buffer: one write port, one synchronous read port with a clearable read register.
module gray_img_ram #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 8
)(
   input  logic              clk,
   input  logic              i_reset_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // Array is deliberately not reset; only the read register is.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gray_img_server.sv
// Gray-image responder: streams one image into the buffer, serves 1-cycle reads until finish.
// Optional read statistics (rd_cnt, row_miss) are built when GRAY_STAT_EN is defined.
module gray_img_server
   import gray_if_pkg::*;
#(
   parameter int unsigned ADDR_W = GRAY_ADDR_W,
   parameter int unsigned DATA_W = GRAY_DATA_W
`ifdef GRAY_STAT_EN
   ,
   parameter int unsigned IMG_W  = GRAY_IMG_W
`endif
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_valid,
   input  logic [DATA_W-1:0]      load_data,
   output logic                   load_ready,
   output logic                   gray_ready,
   input  logic                   gray_req,
   input  logic [ADDR_W-1:0]      gray_addr,
   output logic [DATA_W-1:0]      gray_data,
   input  logic                   finish,
   output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef GRAY_STAT_EN
   ,
   output logic [ADDR_W+3:0]      rd_cnt,
   output logic                   row_miss
`endif
);

   gray_state_e              r_state;
   gray_state_e              w_state_nxt;
   logic [ADDR_W-1:0]        r_ptr;
   logic                     r_load_ready;
   logic                     r_gray_ready;
   logic [FRAME_CNT_W-1:0]   r_frame_cnt;
   logic                     w_wr_en;
   logic                     w_rd_en;
   logic                     w_ptr_last;
   logic [DATA_W-1:0]        w_rd_data;

   assign w_ptr_last = &r_ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_LOAD:  if (w_wr_en && w_ptr_last) w_state_nxt = ST_SERVE;
         ST_SERVE: if (finish) w_state_nxt = ST_DRAIN;
         ST_DRAIN: w_state_nxt = ST_LOAD;
         default:  w_state_nxt = ST_LOAD;
      endcase
   end

   // Writes follow the load_ready handshake, so nothing lands in the reset-exit cycle.
   always_comb begin
      w_wr_en = 1'b0;
      w_rd_en = 1'b0;
      unique case (r_state)
         ST_LOAD:  w_wr_en = r_load_ready & load_valid;
         ST_SERVE: w_rd_en = gray_req;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr        <= '0;
         r_load_ready <= 1'b0;
         r_gray_ready <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         if (w_wr_en) begin
            r_ptr <= r_ptr + ADDR_W'(1);
         end
         if (r_state == ST_DRAIN) begin
            r_ptr       <= '0;
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
         end
         r_load_ready <= (w_state_nxt == ST_LOAD);
         r_gray_ready <= (w_state_nxt == ST_SERVE);
      end
   end

   gray_img_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk       (clk),
      .i_reset_n (reset),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_ptr),
      .i_wr_data (load_data),
      .i_rd_en   (w_rd_en),
      .i_rd_addr (gray_addr),
      .o_rd_data (w_rd_data)
   );

   assign load_ready = r_load_ready;
   assign gray_ready = r_gray_ready;
   assign gray_data  = w_rd_data;
   assign frame_cnt  = r_frame_cnt;

`ifdef GRAY_STAT_EN
   localparam int unsigned ROW_SH = $clog2(IMG_W);
   localparam int unsigned ROW_W  = ADDR_W - ROW_SH;
   localparam int unsigned CNT_W  = ADDR_W + 4;

   logic [ROW_W-1:0] w_cur_row;
   logic [ROW_W-1:0] r_prev_row;
   logic             r_have_prev;
   logic [CNT_W-1:0] r_rd_cnt;
   logic             r_row_miss;
   logic             w_row_back;

   assign w_cur_row  = gray_addr[ADDR_W-1:ROW_SH];
   // Moving up by one row is normal 3x3 window reuse; anything further back is a miss.
   assign w_row_back = r_have_prev &&
                       (({1'b0, w_cur_row} + (ROW_W + 1)'(1)) < {1'b0, r_prev_row});

   always_ff @(posedge clk) begin
      if (!reset || (r_state == ST_DRAIN)) begin
         r_prev_row  <= '0;
         r_have_prev <= 1'b0;
         r_rd_cnt    <= '0;
         r_row_miss  <= 1'b0;
      end else if (w_rd_en) begin
         r_prev_row  <= w_cur_row;
         r_have_prev <= 1'b1;
         r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
         if (w_row_back) begin
            r_row_miss <= 1'b1;
         end
      end
   end

   assign rd_cnt   = r_rd_cnt;
   assign row_miss = r_row_miss;
`endif

endmodule

// File: tb/tb_gray_img_server.sv
// Randomized self-checking bench for gray_img_server against an image-level reference model.
module tb_gray_img_server;

   localparam int unsigned AW   = 14;
   localparam int unsigned DW   = 8;
   localparam int          NPIX = 16384;
   localparam int          P_LOAD  = 0;
   localparam int          P_SERVE = 1;
   localparam int          P_DRAIN = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic          finish;
   wire           load_ready;
   wire           gray_ready;
   wire  [DW-1:0] gray_data;
   wire  [7:0]    frame_cnt;
`ifdef GRAY_STAT_EN
   wire  [AW+3:0] rd_cnt;
   wire           row_miss;
`endif

   always #5 clk = ~clk;

   gray_img_server dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .gray_ready (gray_ready),
      .gray_req   (gray_req),
      .gray_addr  (gray_addr),
      .gray_data  (gray_data),
      .finish     (finish),
      .frame_cnt  (frame_cnt)
`ifdef GRAY_STAT_EN
      ,
      .rd_cnt     (rd_cnt),
      .row_miss   (row_miss)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state: image contents, phase, and what each output must show.
   logic [7:0] mem    [NPIX];
   bit         mem_ok [NPIX];
   bit         m_on = 1'b0;
   int         m_phase = P_LOAD;
   int         m_cnt = 0;
   bit         m_ld_rdy, m_g_rdy, m_gd_ok;
   logic [7:0] m_gd;
   int         m_fcnt;
   int         m_rd;
   bit         m_miss;
   int         m_prev_row;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: cycle budget expired at %0t", nm, $time);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            m_on = 1'b1; m_phase = P_LOAD; m_cnt = 0;
            m_ld_rdy = 1'b0; m_g_rdy = 1'b0; m_gd = 8'h00; m_gd_ok = 1'b1;
            m_fcnt = 0; m_rd = 0; m_miss = 1'b0; m_prev_row = -1;
         end else if (m_on) begin
            case (m_phase)
               P_LOAD: begin
                  if (m_ld_rdy && load_valid) begin
                     mem[m_cnt] = load_data;
                     mem_ok[m_cnt] = 1'b1;
                     m_cnt++;
                     if (m_cnt == NPIX) begin
                        m_cnt = 0;
                        m_phase = P_SERVE;
                     end
                  end
               end
               P_SERVE: begin
                  if (gray_req) begin
                     int row;
                     row = int'(gray_addr) / 128;
                     m_gd = mem[gray_addr];
                     m_gd_ok = mem_ok[gray_addr];
                     m_rd++;
                     if (m_prev_row >= 0 && row < m_prev_row - 1) m_miss = 1'b1;
                     m_prev_row = row;
                  end
                  if (finish) m_phase = P_DRAIN;
               end
               default: begin
                  m_fcnt = (m_fcnt + 1) % 256;
                  m_phase = P_LOAD;
                  m_rd = 0; m_miss = 1'b0; m_prev_row = -1;
               end
            endcase
            m_ld_rdy = (m_phase == P_LOAD);
            m_g_rdy  = (m_phase == P_SERVE);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            chk("load_ready", {31'b0, load_ready}, {31'b0, m_ld_rdy});
            chk("gray_ready", {31'b0, gray_ready}, {31'b0, m_g_rdy});
            chk("frame_cnt", {24'b0, frame_cnt}, 32'(m_fcnt));
            if (m_gd_ok) chk("gray_data", {24'b0, gray_data}, {24'b0, m_gd});
`ifdef GRAY_STAT_EN
            chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
            chk("row_miss", {31'b0, row_miss}, {31'b0, m_miss});
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // kind 0: byte = index, 1: random (index 100 pinned to 0x5A), 2: constant 0xAA.
   task automatic load_img(input int kind, input bit toggle, input int limit);
      int cyc = 0;
      bit v = 1'b1;
      while (m_phase == P_LOAD && m_cnt < limit) begin
         if (cyc > 3 * NPIX) begin
            timeout("load_img");
            break;
         end
         load_valid = toggle ? v : 1'b1;
         v = ~v;
         case (kind)
            0:       load_data = 8'(m_cnt);
            1:       load_data = (m_cnt == 100) ? 8'h5A : 8'($urandom);
            default: load_data = 8'hAA;
         endcase
         step();
         cyc++;
      end
      load_valid = 1'b0;
   endtask

   task automatic rand_reads(input int n);
      for (int i = 0; i < n; i++) begin
         gray_req  = 1'($urandom_range(0, 1));
         gray_addr = AW'($urandom_range(0, NPIX - 1));
         step();
      end
      gray_req = 1'b0;
   endtask

   task automatic rd_one(input int addr);
      gray_req  = 1'b1;
      gray_addr = AW'(addr);
      step();
      gray_req  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; load_valid = 1'b0; load_data = '0;
      gray_req = 1'b0; gray_addr = '0; finish = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_gray_data", {24'b0, gray_data}, 32'h0);
      chk("rst_frame_cnt", {24'b0, frame_cnt}, 32'h0);
      chk("rst_load_ready", {31'b0, load_ready}, 32'h0);
      chk("rst_gray_ready", {31'b0, gray_ready}, 32'h0);

      // Frame 1: byte = address, continuous valid.
      step();
      load_img(0, 1'b0, NPIX);
      @(negedge clk);
      chk("serve_gray_ready", {31'b0, gray_ready}, 32'h1);
      chk("serve_load_ready", {31'b0, load_ready}, 32'h0);
      gray_req = 1'b1; gray_addr = 14'd0;
      @(posedge clk); #1 gray_addr = 14'd129;
      @(negedge clk); chk("rd_addr0", {24'b0, gray_data}, 32'h00);
      @(posedge clk); #1 gray_addr = 14'd16383;
      @(negedge clk); chk("rd_addr129", {24'b0, gray_data}, 32'h81);
      @(posedge clk); #1 gray_req = 1'b0;
      @(negedge clk); chk("rd_addr16383", {24'b0, gray_data}, 32'hFF);
      step();
      rand_reads(200);
      gray_req = 1'b1; gray_addr = 14'd5; finish = 1'b1;
      step();
      gray_req = 1'b0; finish = 1'b0;
      @(negedge clk);
      chk("fin_gray_data", {24'b0, gray_data}, 32'h05);
      chk("fin_gray_ready", {31'b0, gray_ready}, 32'h0);
      step();
      @(negedge clk);
      chk("drain_frame_cnt", {24'b0, frame_cnt}, 32'h1);
      chk("drain_load_ready", {31'b0, load_ready}, 32'h1);
`ifdef GRAY_STAT_EN
      chk("drain_rd_cnt", 32'(rd_cnt), 32'h0);
      chk("drain_row_miss", {31'b0, row_miss}, 32'h0);
`endif

      // Frame 2: random bytes with load_valid toggling.
      step();
      load_img(1, 1'b1, NPIX);
      @(negedge clk);
      rd_one(100);
      chk("rd_byte101", {24'b0, gray_data}, 32'h5A);
      step();
      rand_reads(200);
      gray_req = 1'b1; gray_addr = 14'd100; finish = 1'b1;
      step();
      gray_req = 1'b0; finish = 1'b0;
      step();
      @(negedge clk);
      chk("drain2_frame_cnt", {24'b0, frame_cnt}, 32'h2);

      // Abort a load after 500 bytes with a reset pulse, then stream 0xAA.
      step();
      load_img(0, 1'b0, 500);
      @(negedge clk);
      chk("hold_gray_data", {24'b0, gray_data}, 32'h5A);
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_gray_data", {24'b0, gray_data}, 32'h0);
      chk("rst2_frame_cnt", {24'b0, frame_cnt}, 32'h0);
      step();
      load_img(2, 1'b0, NPIX);
      @(negedge clk);
`ifdef GRAY_STAT_EN
      rd_one(10 * 128 + 3);
      rd_one(9 * 128 + 100);
      chk("stat_no_miss", {31'b0, row_miss}, 32'h0);
      rd_one(2 * 128);
      chk("stat_miss", {31'b0, row_miss}, 32'h1);
      chk("stat_rd_cnt", 32'(rd_cnt), 32'h3);
`endif
      for (int i = 0; i < 60; i++) begin
         rd_one(int'($urandom_range(0, NPIX - 1)));
         chk("rd_aa", {24'b0, gray_data}, 32'hAA);
      end

      // Reset in the middle of serving, with a request pending.
      step();
      gray_req = 1'b1; gray_addr = 14'd77; reset = 1'b0;
      step();
      gray_req = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("rst3_gray_data", {24'b0, gray_data}, 32'h0);
      chk("rst3_gray_ready", {31'b0, gray_ready}, 32'h0);
`ifdef GRAY_STAT_EN
      chk("rst3_rd_cnt", 32'(rd_cnt), 32'h0);
`endif
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_img_server.md
Name: gray_img_server

Overview:
- Image-side responder for the LBP gray-image read interface.
- Holds one 128x128 8-bit gray image in an internal buffer. The buffer is filled over a byte-stream load port.
- Raises gray_ready once the full image is resident, then answers gray_req/gray_addr with gray_data at fixed 1-cycle latency.
- Returns to load state when the LBP engine asserts finish, so the next frame can be streamed in.

Parameters:
- ADDR_W, 14, gray address width; buffer depth is 2**ADDR_W.
- DATA_W, 8, pixel width.
- IMG_W, 128, image row length; informational, used only by the optional statistics.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- load_valid  input  1  load byte present on load_data.
- load_data  input  DATA_W  pixel byte, raster order starting at address 0.
- load_ready  output  1  block accepts load bytes (LOAD state).
- gray_ready  output  1  image resident; reads permitted.
- gray_req  input  1  read request from the LBP engine.
- gray_addr  input  ADDR_W  pixel address of the request.
- gray_data  output  DATA_W  registered read data.
- finish  input  1  LBP engine done with the current frame.
- frame_cnt  output  8  number of completed frames; wraps at 255->0.

Behaviour:
- Reset (reset==0 at rising clk):
  - State goes to LOAD; load pointer = 0.
  - load_ready=0 on the reset cycle, 1 from the first non-reset cycle.
  - gray_ready=0, gray_data=0, frame_cnt=0.
  - Buffer contents are not cleared.
- States: LOAD, SERVE, DRAIN.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1 writes load_data to buf[ptr] and increments ptr.
  - On the write where ptr==2**ADDR_W-1: ptr wraps to 0 and the state goes to SERVE. gray_ready=1 from the next cycle.
  - gray_req is ignored and gray_data holds its value.
  - finish is ignored.
- SERVE:
  - load_ready=0; load_valid is ignored, with no write and no pointer change.
  - gray_req=1 at edge N: gray_data takes buf[gray_addr] at edge N+1, i.e. valid in the cycle after the request. Back-to-back requests are sustained at one per cycle.
  - gray_req=0: gray_data holds its last value.
  - finish=1: go to DRAIN, gray_ready=0 from the next cycle. A request sampled in the same cycle as finish is still served.
- DRAIN:
  - One cycle; frame_cnt increments (mod 256); go to LOAD with ptr=0.
  - gray_req is ignored.
- Simultaneous events:
  - Reset dominates everything.
  - In LOAD, a load write and a gray_req are independent; the request is ignored.
- Reset mid-load: ptr returns to 0 and already-written bytes are overwritten by the new stream.
- Reset mid-serve: gray_ready drops on the next edge. An outstanding read is abandoned and gray_data=0.
- Buffer: single write port (load) and single synchronous read port (serve). Write and read never occur in the same state, so no bypass is required.

Optional Feature:
- GRAY_STAT_EN defined:
  - Adds outputs rd_cnt (ADDR_W+4 bits, requests served this frame) and row_miss (1 bit).
  - row_miss is sticky; it sets when a SERVE request addresses a row more than 1 below the row of the previous request, i.e. a non-monotonic scan beyond 3x3 window reuse.
  - Both outputs clear on entry to LOAD and on reset.
- GRAY_STAT_EN not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package gray_if_pkg:
  - state encoding LOAD=2'd0, SERVE=2'd1, DRAIN=2'd2;
  - ADDR_W/DATA_W defaults;
  - IMG_PIXELS = 16384.
- One sub-module, gray_img_ram: depth 2**ADDR_W x DATA_W, one write port, one synchronous read port, no reset on the array.
- The FSM, pointer and optional statistics stay in the top.

Test Plan:
- Reset, then stream 16384 bytes with load_data = addr[7:0] and load_valid always 1:
  - load_ready=1 throughout;
  - gray_ready rises exactly one cycle after the 16384th write;
  - load_ready falls with it.
- In SERVE, gray_req=1 with gray_addr=0, 129, 16383 on consecutive cycles -> gray_data = 0x00, 0x81, 0xFF on the following three cycles.
- Load stream with load_valid toggling 1/0 -> only valid cycles write; the 16384th accepted byte triggers SERVE. Readback of addr 100 returns the 101st accepted byte.
- In SERVE, assert finish for 1 cycle together with gray_req, addr=5:
  - gray_data=0x05 next cycle;
  - gray_ready=0 next cycle;
  - frame_cnt=1 after DRAIN;
  - load_ready=1 one cycle later.
- Reset pulse after 500 loaded bytes, then a full stream of 0xAA -> all reads return 0xAA, gray_data=0 immediately after reset.
- With GRAY_STAT_EN, read rows 10 then 2 -> row_miss=1. rd_cnt equals the number of requests, and it clears to 0 on entry to LOAD.
